// File: rtl/lfsr_run_ctrl.sv
// Run controller for an LFSR generator + accumulator: seed, warm up, sync to wrap, accumulate N periods.
// Optional ACCUM period check enabled by defining LFSR_RUN_CTRL_PERIOD_CHECK_EN.
module lfsr_run_ctrl #(
  parameter int unsigned PERIOD     = 4194303,
  parameter int unsigned WARMUP     = 16,
  parameter int unsigned NUM_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sym_strobe,
  input  logic       start,
  input  logic       abort,
  input  logic       cycle_wrap,
  output logic       lfsr_rst,
  output logic       lfsr_en,
  output logic       acc_clr,
  output logic       acc_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] cycles_done,
  output logic       period_err
);

  localparam int unsigned CntMax = (PERIOD > WARMUP) ? PERIOD : WARMUP;
  localparam int unsigned CW = (CntMax > 1) ? $clog2(CntMax + 1) : 1;
  localparam logic [CW-1:0] WarmLast   = CW'(WARMUP - 1);
  localparam logic [CW-1:0] PeriodLast = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CntOne     = CW'(1);
  localparam logic [7:0]    CyclesLast = 8'(NUM_CYCLES);

  typedef enum logic [2:0] {StIdle, StSeed, StWarmup, StSync, StAccum, StDone} state_e;

  state_e        state_q, state_d;
  logic          seed_idx_q, seed_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    cycles_q, cycles_d;
  logic          err_q, err_d;
  logic          wrap;

  // cycle_wrap is only meaningful on symbol strobes
  assign wrap        = sym_strobe & cycle_wrap;
  assign busy        = (state_q != StIdle);
  assign cycles_done = cycles_q;
  assign period_err  = err_q;

  always_comb begin
    state_d    = state_q;
    seed_idx_d = 1'b0;
    cnt_d      = cnt_q;
    cycles_d   = cycles_q;
    err_d      = err_q;
    lfsr_rst   = 1'b0;
    lfsr_en    = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StSeed;
          cnt_d    = '0;
          cycles_d = '0;
          err_d    = 1'b0;
        end
      end
      StSeed: begin
        lfsr_rst   = 1'b1;
        acc_clr    = ~seed_idx_q;
        seed_idx_d = 1'b1;
        if (seed_idx_q) begin
          state_d    = StWarmup;
          seed_idx_d = 1'b0;
          cnt_d      = '0;
        end
      end
      StWarmup: begin
        lfsr_en = sym_strobe;
        if (sym_strobe) begin
          if (cnt_q == WarmLast) begin
            state_d = StSync;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end
      StSync: begin
        lfsr_en = sym_strobe;
        if (wrap) begin
          state_d = StAccum;
          cnt_d   = '0;
        end else if (sym_strobe) begin
          if (cnt_q == PeriodLast) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end
      StAccum: begin
        lfsr_en = sym_strobe;
        acc_en  = sym_strobe;
        if (wrap) begin
          cycles_d = cycles_q + 8'd1;
`ifdef LFSR_RUN_CTRL_PERIOD_CHECK_EN
          if (cnt_q != PeriodLast) err_d = 1'b1;
          cnt_d = '0;
`endif
          if (cycles_q + 8'd1 == CyclesLast) state_d = StDone;
        end
`ifdef LFSR_RUN_CTRL_PERIOD_CHECK_EN
        else if (sym_strobe) begin
          cnt_d = cnt_q + CntOne;
        end
`else
`endif
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Abort overrides any wrap, timeout or completion seen in the same cycle
    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      seed_idx_d = 1'b0;
      cnt_d      = '0;
      cycles_d   = cycles_q;
      err_d      = err_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      seed_idx_q <= 1'b0;
      cnt_q      <= '0;
      cycles_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_idx_q <= seed_idx_d;
      cnt_q      <= cnt_d;
      cycles_q   <= cycles_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Randomized bench for lfsr_run_ctrl: per-run wrap schedules scored against an event-level model.
module tb_lfsr_run_ctrl;
  localparam int unsigned PERIOD     = 15;
  localparam int unsigned WARMUP     = 3;
  localparam int unsigned NUM_CYCLES = 2;
`ifdef LFSR_RUN_CTRL_PERIOD_CHECK_EN
  localparam bit PeriodCheckEn = 1'b1;
`else
  localparam bit PeriodCheckEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sym_strobe = 1'b0, start = 1'b0, abort = 1'b0, cycle_wrap = 1'b0;
  logic       lfsr_rst, lfsr_en, acc_clr, acc_en, busy, done, period_err;
  logic [7:0] cycles_done;

  always #5 clk = ~clk;

  lfsr_run_ctrl #(.PERIOD(PERIOD), .WARMUP(WARMUP), .NUM_CYCLES(NUM_CYCLES)) dut (
    .clk(clk), .reset(reset), .sym_strobe(sym_strobe), .start(start), .abort(abort),
    .cycle_wrap(cycle_wrap), .lfsr_rst(lfsr_rst), .lfsr_en(lfsr_en), .acc_clr(acc_clr),
    .acc_en(acc_en), .busy(busy), .done(done), .cycles_done(cycles_done),
    .period_err(period_err)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output event counters, sampled mid-cycle
  int c_rst = 0, c_clr = 0, c_acc = 0, c_en = 0, c_done = 0;
  always @(negedge clk) begin
    if (lfsr_rst === 1'b1) c_rst <= c_rst + 1;
    if (acc_clr === 1'b1) c_clr <= c_clr + 1;
    if (acc_en === 1'b1) c_acc <= c_acc + 1;
    if (lfsr_en === 1'b1) c_en <= c_en + 1;
    if (done === 1'b1) c_done <= c_done + 1;
  end

  bit wq[$];  // cycle_wrap value per symbol strobe, strobe 0 = first strobe after seeding
  int abort_k = -1, start_k = -1, reset_k = -1, noise_pct = 20;

  task automatic gen(input int kind);
    int g;
    wq.delete();
    repeat (WARMUP) wq.push_back(bit'($urandom_range(1)));
    case (kind)
      0, 1, 4: begin
        repeat ($urandom_range(6)) wq.push_back(1'b0);
        wq.push_back(1'b1);
        for (int c = 0; c <= NUM_CYCLES; c++) begin
          if (kind == 0) g = PERIOD;
          else if (kind == 1) g = (c == 0) ? 10 : PERIOD;
          else g = $urandom_range(1) ? PERIOD : $urandom_range(3, PERIOD + 5);
          repeat (g - 1) wq.push_back(1'b0);
          wq.push_back(1'b1);
        end
      end
      2: repeat (PERIOD + 10) wq.push_back(1'b0);
      default: repeat (120) wq.push_back($urandom_range(5) == 0);
    endcase
    repeat (10) wq.push_back(1'b0);
  endtask

  // Reference: locate the sync wrap, then walk the accumulate window wrap by wrap
  task automatic model(output int e_end, output int e_acc, output int e_en, output int e_cyc,
                       output int e_err, output bit ok);
    int j, last, n, short_gaps;
    j = -1; n = wq.size(); short_gaps = 0;
    e_acc = 0; e_cyc = 0; e_err = 0; e_end = -1;
    for (int i = WARMUP; i < WARMUP + PERIOD && i < n; i++)
      if (wq[i] && j < 0) j = i;
    if (j < 0) begin
      e_end = WARMUP + PERIOD - 1;
      e_err = 1;
      e_en  = WARMUP + PERIOD;
      ok    = (n > e_end);
    end else begin
      last = j;
      for (int i = j + 1; i < n && e_end < 0; i++) begin
        e_acc++;
        if (wq[i]) begin
          if (i - last != PERIOD) short_gaps++;
          last = i;
          e_cyc++;
          if (e_cyc == NUM_CYCLES) e_end = i;
        end
      end
      e_err = (PeriodCheckEn && short_gaps > 0) ? 1 : 0;
      e_en  = (j + 1) + e_acc;
      ok    = (e_end >= 0);
    end
  endtask

  task automatic drive_run(input int last_k, output bit got_done);
    int  k, d0;
    bit  abort_seen;
    k = 0; d0 = c_done; abort_seen = 0; got_done = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 4 * (last_k + 8); cyc++) begin
      @(posedge clk); #1;
      if (abort_seen) begin
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        break;
      end
      if (c_done != d0) begin
        got_done = 1;
        break;
      end
      sym_strobe = 1'b0; start = 1'b0; abort = 1'b0;
      cycle_wrap = ($urandom_range(99) < noise_pct);
      if (cyc % 4 == 3) begin
        sym_strobe = 1'b1;
        cycle_wrap = (k < wq.size()) ? wq[k] : 1'b0;
        start      = (k == start_k);
        abort      = (k == abort_k);
        abort_seen = abort;
        if (k == reset_k) begin
          #2 check("pre_reset_acc_en", acc_en, 1);
          reset = 1'b1;
          #1 check("reset_outputs",
                   {busy, done, lfsr_rst, lfsr_en, acc_clr, acc_en, period_err, cycles_done}, 0);
          @(posedge clk); #1 reset = 1'b0; sym_strobe = 1'b0; cycle_wrap = 1'b0;
          @(posedge clk); #1 check("reset_idle", busy, 0);
          break;
        end
        k++;
      end
    end
    sym_strobe = 1'b0; cycle_wrap = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_full(input string tag);
    int e_end, e_acc, e_en, e_cyc, e_err;
    int r0, c0, a0, n0, d0;
    bit ok, got;
    model(e_end, e_acc, e_en, e_cyc, e_err, ok);
    r0 = c_rst; c0 = c_clr; a0 = c_acc; n0 = c_en; d0 = c_done;
    drive_run(e_end, got);
    check($sformatf("%s_done_seen", tag), got, 1);
    check($sformatf("%s_done_pulses", tag), c_done - d0, 1);
    check($sformatf("%s_lfsr_rst_clks", tag), c_rst - r0, 2);
    check($sformatf("%s_acc_clr_clks", tag), c_clr - c0, 1);
    check($sformatf("%s_acc_en_strobes", tag), c_acc - a0, e_acc);
    check($sformatf("%s_lfsr_en_strobes", tag), c_en - n0, e_en);
    check($sformatf("%s_cycles_done", tag), cycles_done, e_cyc);
    check($sformatf("%s_period_err", tag), period_err, e_err);
    check($sformatf("%s_busy_after", tag), busy, 0);
  endtask

  initial begin
    int e_end, e_acc, e_en, e_cyc, e_err, d0;
    bit ok, got;
    #1 check("in_reset_outputs",
             {busy, done, lfsr_rst, lfsr_en, acc_clr, acc_en, period_err, cycles_done}, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("post_reset_outputs",
             {busy, done, lfsr_rst, lfsr_en, acc_clr, acc_en, period_err, cycles_done}, 0);

    gen(0); run_full("nominal");
    gen(1); run_full("short_period");
    gen(2); run_full("missing_wrap");
    noise_pct = 100; gen(0); run_full("offstrobe_wrap"); noise_pct = 20;

    gen(0); model(e_end, e_acc, e_en, e_cyc, e_err, ok);
    start_k = $urandom_range(e_end - 1);
    run_full("restart_busy");
    start_k = -1;

    // Abort on the wrap that would otherwise complete the run
    gen(0); model(e_end, e_acc, e_en, e_cyc, e_err, ok);
    abort_k = e_end; d0 = c_done;
    drive_run(e_end, got);
    check("abort_done_pulses", c_done - d0, 0);
    check("abort_cycles_done", cycles_done, NUM_CYCLES - 1);
    check("abort_period_err", period_err, 0);
    abort_k = -1;
    gen(0); run_full("after_abort");

    gen(0); model(e_end, e_acc, e_en, e_cyc, e_err, ok);
    reset_k = e_end - 3;
    drive_run(e_end, got);
    reset_k = -1;
    gen(4); run_full("after_reset");

    for (int r = 0; r < 12; r++) begin
      ok = 0;
      while (!ok) begin
        gen($urandom_range(4));
        model(e_end, e_acc, e_en, e_cyc, e_err, ok);
      end
      run_full($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
